// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: shared constants and types for the write-back trap sequencer.
//   - exception codes and subcodes driven to the CSR file
//   - CSR instruction encodings carried on ws_csr_op
//   - bit positions inside ws_ex_vec ({ALE, BRK, SYS, INE, ADEF})
//   - sequencer state and bad-address source selection
package csr_trap_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [8:0] ESUB_ADEF = 9'd0;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RD   = 2'b01;
    localparam logic [1:0] CSR_OP_WR   = 2'b10;
    localparam logic [1:0] CSR_OP_XCHG = 2'b11;

    localparam int EX_ADEF = 0;
    localparam int EX_INE  = 1;
    localparam int EX_SYS  = 2;
    localparam int EX_BRK  = 3;
    localparam int EX_ALE  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    // Which value is reported as the bad virtual address of a trap.
    typedef enum logic [1:0] {
        VA_ZERO,
        VA_PC,
        VA_BADV
    } vaddr_sel_t;

endpackage

// File: rtl/csr_trap_ctrl_prio.sv
// csr_trap_prio: pure priority encoder for trap causes.
//   int_pend   in   registered interrupt request (highest priority)
//   ex_vec     in   {ALE, BRK, SYS, INE, ADEF} exception flags
//   trap       out  some cause is present
//   ecode      out  exception code of the winning cause
//   esubcode   out  exception subcode of the winning cause
//   vaddr_sel  out  source of the bad virtual address
module csr_trap_prio
    import csr_trap_ctrl_pkg::*;
(
    input  logic       int_pend,
    input  logic [4:0] ex_vec,
    output logic       trap,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output vaddr_sel_t vaddr_sel
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // if-chain leaves one unassigned, which would infer a latch.
        trap      = 1'b1;
        ecode     = ECODE_INT;
        esubcode  = 9'd0;
        vaddr_sel = VA_ZERO;
        if (int_pend) begin
            ecode = ECODE_INT;
        end else if (ex_vec[EX_ADEF]) begin
            ecode     = ECODE_ADE;
            esubcode  = ESUB_ADEF;
            vaddr_sel = VA_PC;
        end else if (ex_vec[EX_INE]) begin
            ecode = ECODE_INE;
        end else if (ex_vec[EX_SYS]) begin
            ecode = ECODE_SYS;
        end else if (ex_vec[EX_BRK]) begin
            ecode = ECODE_BRK;
        end else if (ex_vec[EX_ALE]) begin
            ecode     = ECODE_ALE;
            vaddr_sel = VA_BADV;
        end else begin
            trap = 1'b0;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: write-back stage trap sequencer in front of the CSR file.
// Arbitrates interrupt / exception / ERTN / CSR access for the WB instruction,
// drives the CSR file strobes in the commit cycle and then holds a redirect
// to fetch (FLUSH) until fetch accepts it.
// Ports:
//   clk, resetn                      clock, synchronous active-low reset
//   ws_valid/ws_ready                WB handshake (ready low while flushing)
//   ws_pc, ws_ex_vec, ws_vaddr       WB instruction PC, exception flags, data address
//   ws_is_ertn, ws_csr_*             ERTN flag and CSR instruction fields
//   ws_csr_rdata                     old CSR value returned to WB
//   has_int, ex_entry, ertn_entry    interrupt request and redirect targets
//   csr_rvalue, csr_re/we/num/wmask/wvalue   CSR file access port
//   wb_ex, ertn_flush, wb_csr_pc, wb_vaddr, wb_ecode, wb_esubcode  trap report
//   flush_valid/flush_pc/flush_ready redirect handshake to fetch
// Optional build macro CSR_TRAP_STATS_EN adds saturating STAT_W-bit counters
// int_cnt, exc_cnt and ertn_cnt.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int STAT_W = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_valid,
    output logic        ws_ready,
    input  logic [31:0] ws_pc,
    input  logic [4:0]  ws_ex_vec,
    input  logic [31:0] ws_vaddr,
    input  logic        ws_is_ertn,
    input  logic [1:0]  ws_csr_op,
    input  logic [13:0] ws_csr_num,
    input  logic [31:0] ws_csr_mask,
    input  logic [31:0] ws_csr_wdata,
    output logic [31:0] ws_csr_rdata,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    input  logic [31:0] csr_rvalue,
    output logic        csr_re,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] wb_csr_pc,
    output logic [31:0] wb_vaddr,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        flush_valid,
    output logic [31:0] flush_pc,
    input  logic        flush_ready
`ifdef CSR_TRAP_STATS_EN
    ,
    output logic [STAT_W-1:0] int_cnt,
    output logic [STAT_W-1:0] exc_cnt,
    output logic [STAT_W-1:0] ertn_cnt
`endif
);

    state_t     state, state_nxt;
    logic       int_pend;
    logic [31:0] target;

    logic       prio_trap;
    logic [5:0] prio_ecode;
    logic [8:0] prio_esub;
    vaddr_sel_t prio_vsel;

    csr_trap_prio u_prio (
        .int_pend  (int_pend),
        .ex_vec    (ws_ex_vec),
        .trap      (prio_trap),
        .ecode     (prio_ecode),
        .esubcode  (prio_esub),
        .vaddr_sel (prio_vsel)
    );

    // Decisions are only taken in IDLE; a trap suppresses ERTN and CSR access.
    logic commit, do_trap, do_ertn, do_csr, csr_write;
    assign commit    = (state == ST_IDLE) && ws_valid;
    assign do_trap   = commit && prio_trap;
    assign do_ertn   = commit && !prio_trap && ws_is_ertn;
    assign do_csr    = commit && !prio_trap && (ws_csr_op != CSR_OP_NONE);
    assign csr_write = do_csr && (ws_csr_op == CSR_OP_WR || ws_csr_op == CSR_OP_XCHG);

    // State register, interrupt sample and redirect target.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge value of its inputs.
        if (!resetn) begin
            state    <= ST_IDLE;
            int_pend <= 1'b0;
            target   <= 32'd0;
        end else begin
            state    <= state_nxt;
            int_pend <= has_int;
            // The target is captured at commit so it stays stable in FLUSH
            // even if the CSR file changes ex_entry/ertn_entry meanwhile.
            if (do_trap) begin
                target <= ex_entry;
            end else if (do_ertn) begin
                target <= ertn_entry;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (do_trap || do_ertn) state_nxt = ST_FLUSH;
            ST_FLUSH: if (flush_ready)        state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        ws_ready     = (state == ST_IDLE);
        flush_valid  = (state == ST_FLUSH);
        flush_pc     = (state == ST_FLUSH) ? target : 32'd0;

        wb_ex        = do_trap;
        ertn_flush   = do_ertn;
        wb_csr_pc    = do_trap ? ws_pc      : 32'd0;
        wb_ecode     = do_trap ? prio_ecode : 6'd0;
        wb_esubcode  = do_trap ? prio_esub  : 9'd0;
        wb_vaddr     = 32'd0;
        if (do_trap) begin
            case (prio_vsel)
                VA_PC:   wb_vaddr = ws_pc;
                VA_BADV: wb_vaddr = ws_vaddr;
                default: wb_vaddr = 32'd0;
            endcase
        end

        csr_re       = do_csr;
        csr_we       = csr_write;
        csr_num      = do_csr ? ws_csr_num   : 14'd0;
        csr_wvalue   = do_csr ? ws_csr_wdata : 32'd0;
        ws_csr_rdata = do_csr ? csr_rvalue   : 32'd0;
        csr_wmask    = 32'd0;
        if (do_csr && ws_csr_op == CSR_OP_WR) begin
            csr_wmask = 32'hFFFF_FFFF;
        end else if (do_csr && ws_csr_op == CSR_OP_XCHG) begin
            csr_wmask = ws_csr_mask;
        end
    end

`ifdef CSR_TRAP_STATS_EN
    // Saturating commit counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            int_cnt  <= '0;
            exc_cnt  <= '0;
            ertn_cnt <= '0;
        end else begin
            if (do_trap && int_pend && int_cnt != '1) begin
                int_cnt <= int_cnt + 1'b1;
            end
            if (do_trap && !int_pend && exc_cnt != '1) begin
                exc_cnt <= exc_cnt + 1'b1;
            end
            if (do_ertn && ertn_cnt != '1) begin
                ertn_cnt <= ertn_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// tb_csr_trap_ctrl: scoreboard bench for csr_trap_ctrl (default build).
// The driver applies directed and random WB instructions, predicts the
// commit-cycle strobes and redirect target from the trap rules, and queues
// them; a negedge monitor pops and compares whenever the DUT presents them.
module tb_csr_trap_ctrl;

    logic        clk;
    logic        resetn;
    logic        ws_valid, ws_ready;
    logic [31:0] ws_pc;
    logic [4:0]  ws_ex_vec;
    logic [31:0] ws_vaddr;
    logic        ws_is_ertn;
    logic [1:0]  ws_csr_op;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_csr_mask, ws_csr_wdata, ws_csr_rdata;
    logic        has_int;
    logic [31:0] ex_entry, ertn_entry, csr_rvalue;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        wb_ex, ertn_flush;
    logic [31:0] wb_csr_pc, wb_vaddr;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        flush_ready;

    csr_trap_ctrl #(.STAT_W(16)) dut (
        .clk(clk), .resetn(resetn),
        .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc),
        .ws_ex_vec(ws_ex_vec), .ws_vaddr(ws_vaddr), .ws_is_ertn(ws_is_ertn),
        .ws_csr_op(ws_csr_op), .ws_csr_num(ws_csr_num), .ws_csr_mask(ws_csr_mask),
        .ws_csr_wdata(ws_csr_wdata), .ws_csr_rdata(ws_csr_rdata),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .csr_rvalue(csr_rvalue), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_csr_pc(wb_csr_pc),
        .wb_vaddr(wb_vaddr), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .flush_valid(flush_valid), .flush_pc(flush_pc), .flush_ready(flush_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ex, ertn, re, we;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] csr_pc, vaddr;
        logic [13:0] num;
        logic [31:0] wmask, wvalue, rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] flush_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          passed = 0;
    bit          mon_en = 0;
    logic        prev_int = 1'b0;   // model of the registered interrupt request
    logic [31:0] csr_mem [logic [13:0]];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    endtask

    // Advance one clock; the model's interrupt sample follows the DUT's rule.
    task automatic step();
        logic nxt;
        nxt = resetn ? has_int : 1'b0;
        @(posedge clk);
        #1;
        prev_int = nxt;
    endtask

    // Random inputs that must have no effect (idle or flushing cycles).
    task automatic junk(input logic valid);
        ws_valid     = valid;
        ws_pc        = $urandom;
        ws_ex_vec    = 5'($urandom);
        ws_vaddr     = $urandom;
        ws_is_ertn   = 1'($urandom);
        ws_csr_op    = 2'($urandom);
        ws_csr_num   = 14'($urandom);
        ws_csr_mask  = $urandom;
        ws_csr_wdata = $urandom;
        ex_entry     = $urandom;
        ertn_entry   = $urandom;
        csr_rvalue   = $urandom;
        has_int      = ($urandom_range(0, 3) == 0);
    endtask

    task automatic idle_cycle(input logic hint);
        junk(1'b0);
        has_int = hint;
        step();
    endtask

    // Reference rules: interrupt first, then ADEF > INE > SYS > BRK > ALE.
    task automatic apply_txn(input logic [31:0] pc, input logic [4:0] exv, input logic ertn,
                             input logic [1:0] op, input logic [13:0] num,
                             input logic [31:0] mask, input logic [31:0] wdata,
                             input logic [31:0] vaddr, input logic [31:0] exent,
                             input logic [31:0] ertent, input logic hint, output bit flush);
        exp_t        e;
        int          order[5] = '{0, 1, 2, 3, 4};
        logic [5:0]  codes[5] = '{6'h08, 6'h0D, 6'h0B, 6'h0C, 6'h09};
        int          src;
        logic [31:0] old;
        e = '{ex: 1'b0, ertn: 1'b0, re: 1'b0, we: 1'b0, ecode: 6'd0, esub: 9'd0,
              csr_pc: 32'd0, vaddr: 32'd0, num: 14'd0, wmask: 32'd0, wvalue: 32'd0,
              rdata: 32'd0};
        old = csr_mem.exists(num) ? csr_mem[num] : 32'd0;
        src = -2;
        if (prev_int) src = -1;
        else for (int i = 0; i < 5; i++) if (src == -2 && exv[order[i]]) src = i;
        if (src != -2) begin
            e.ex     = 1'b1;
            e.csr_pc = pc;
            e.ecode  = (src == -1) ? 6'h00 : codes[src];
            e.vaddr  = (src == 0) ? pc : (src == 4) ? vaddr : 32'd0;
            flush_q.push_back(exent);
        end else begin
            if (ertn) begin
                e.ertn = 1'b1;
                flush_q.push_back(ertent);
            end
            if (op != 2'b00) begin
                e.re     = 1'b1;
                e.num    = num;
                e.rdata  = old;
                e.wvalue = wdata;
                if (op == 2'b10) e.wmask = 32'hFFFF_FFFF;
                if (op == 2'b11) e.wmask = mask;
                e.we = (op[1] == 1'b1);
                if (e.we) csr_mem[num] = (old & ~e.wmask) | (wdata & e.wmask);
            end
        end
        flush = e.ex || e.ertn;
        if (e.ex || e.ertn || e.re) exp_q.push_back(e);
        ws_valid = 1'b1; ws_pc = pc; ws_ex_vec = exv; ws_vaddr = vaddr;
        ws_is_ertn = ertn; ws_csr_op = op; ws_csr_num = num; ws_csr_mask = mask;
        ws_csr_wdata = wdata; ex_entry = exent; ertn_entry = ertent;
        csr_rvalue = old; has_int = hint; flush_ready = 1'b0;
    endtask

    task automatic run_txn(input logic [31:0] pc, input logic [4:0] exv, input logic ertn,
                           input logic [1:0] op, input logic [13:0] num,
                           input logic [31:0] mask, input logic [31:0] wdata,
                           input logic [31:0] vaddr, input logic [31:0] exent,
                           input logic [31:0] ertent, input int hold);
        bit flush;
        apply_txn(pc, exv, ertn, op, num, mask, wdata, vaddr, exent, ertent,
                  ($urandom_range(0, 4) == 0), flush);
        check("ready_in_idle", ws_ready, 1'b1);
        step();
        check("commit_seen", exp_q.size(), 0);
        if (flush) begin
            check("flush_rise", flush_valid, 1'b1);
            for (int i = 0; i < hold; i++) begin
                junk(1'b1);
                flush_ready = 1'b0;
                step();
            end
            junk(1'b1);
            flush_ready = 1'b1;
            step();
            flush_ready = 1'b0;
            check("flush_done", flush_q.size(), 0);
        end
        ws_valid = 1'b0;
        check("back_idle", {flush_valid, ws_ready}, 2'b01);
    endtask

    // Monitor: compares whatever the DUT presents against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_ex === 1'b1 || ertn_flush === 1'b1 || csr_re === 1'b1 || csr_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("spurious_strobe", {wb_ex, ertn_flush, csr_re, csr_we}, 4'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wb_ex", wb_ex, mon_e.ex);
                    check("ertn_flush", ertn_flush, mon_e.ertn);
                    check("csr_re", csr_re, mon_e.re);
                    check("csr_we", csr_we, mon_e.we);
                    check("wb_ecode", wb_ecode, mon_e.ecode);
                    check("wb_esubcode", wb_esubcode, mon_e.esub);
                    check("wb_csr_pc", wb_csr_pc, mon_e.csr_pc);
                    check("wb_vaddr", wb_vaddr, mon_e.vaddr);
                    check("csr_num", csr_num, mon_e.num);
                    check("csr_wmask", csr_wmask, mon_e.wmask);
                    check("csr_wvalue", csr_wvalue, mon_e.wvalue);
                    check("ws_csr_rdata", ws_csr_rdata, mon_e.rdata);
                end
            end
            if (flush_valid === 1'b1) begin
                if (flush_q.size() == 0) begin
                    check("spurious_flush", flush_valid, 1'b0);
                end else begin
                    check("flush_pc", flush_pc, flush_q[0]);
                    check("ws_ready_in_flush", ws_ready, 1'b0);
                    if (flush_ready) void'(flush_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit flush;
        resetn = 1'b0;
        flush_ready = 1'b0;
        junk(1'b0);
        has_int = 1'b0;
        step();
        step();
        // Reset state.
        check("rst_flush_valid", flush_valid, 1'b0);
        check("rst_flush_pc", flush_pc, 32'd0);
        check("rst_wb_ex", wb_ex, 1'b0);
        check("rst_ertn_flush", ertn_flush, 1'b0);
        check("rst_csr_we", csr_we, 1'b0);
        check("rst_ws_ready", ws_ready, 1'b1);
        resetn = 1'b1;
        mon_en = 1'b1;
        idle_cycle(1'b0);

        // csrxchg of CSR 0x30: masked write, old value returned.
        csr_mem[14'h30] = 32'hA5A5_A5A0;
        run_txn(32'h1c00_0000, 5'b0, 1'b0, 2'b11, 14'h30, 32'h0000_000F, 32'h5,
                32'h0, 32'h1c00_8000, 32'h0, 0);
        // SYS, redirect held for 3 cycles of flush_ready=0.
        idle_cycle(1'b0);
        run_txn(32'h1c00_0100, 5'b00100, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
                32'h0, 32'h1c00_8000, 32'h1c00_0200, 3);
        // Interrupt sampled one cycle before a csrwr.
        idle_cycle(1'b1);
        run_txn(32'h1c00_0040, 5'b0, 1'b0, 2'b10, 14'h5, 32'h0, 32'h1234_5678,
                32'h0, 32'h1c00_9000, 32'h0, 1);
        // ERTN together with ALE: ALE wins.
        idle_cycle(1'b0);
        run_txn(32'h1c00_0080, 5'b10000, 1'b1, 2'b00, 14'h0, 32'h0, 32'h0,
                32'hDEAD_BEE1, 32'h1c00_8000, 32'h1c00_0200, 0);
        // Plain ERTN.
        idle_cycle(1'b0);
        run_txn(32'h1c00_0090, 5'b0, 1'b1, 2'b00, 14'h0, 32'h0, 32'h0,
                32'h0, 32'h1c00_8000, 32'h1c00_0200, 2);
        // ADEF at a misaligned PC.
        idle_cycle(1'b0);
        run_txn(32'h1c00_0003, 5'b00001, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
                32'h1111_2222, 32'h1c00_8000, 32'h0, 1);

        // Reset while flushing.
        idle_cycle(1'b0);
        apply_txn(32'h1c00_0100, 5'b00100, 1'b0, 2'b00, 14'h0, 32'h0, 32'h0,
                  32'h0, 32'h1c00_8000, 32'h0, 1'b0, flush);
        step();
        check("rst_flush_rise", flush_valid, 1'b1);
        junk(1'b0);
        has_int = 1'b0;
        step();
        resetn = 1'b0;
        step();
        flush_q.delete();
        check("rst_in_flush_valid", flush_valid, 1'b0);
        check("rst_in_flush_wb_ex", wb_ex, 1'b0);
        check("rst_in_flush_ready", ws_ready, 1'b1);
        resetn = 1'b1;
        step();

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 2)) idle_cycle(($urandom_range(0, 3) == 0));
            run_txn($urandom, ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0,
                    ($urandom_range(0, 5) == 0), 2'($urandom), 14'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3));
        end
        idle_cycle(1'b0);
        check("queues_empty", exp_q.size() + flush_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
